matrix_driver: RTL and testbench

- Scan driver for a HUB75-style RGB LED matrix panel with two half-panels driven in parallel (upper and lower).
- Fetches 24-bit pixels for one column at a time from an external frame buffer, which is indexed by {select, addr}.
- Serialises one bit-plane per pass onto rgb1/rgb2 with sclk, then latches it and enables the LEDs for a binary-weighted time (binary code modulation, 8 planes).
- Sits between the frame buffer and the panel connector.

---
 rtl/matrix_driver_if.sv | 25 ++
 rtl/matrix_driver.sv | 144 ++++++++++++++
 tb/tb_matrix_driver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_driver_if.sv
// Panel-side and frame-buffer-side signals of the HUB75 scan driver.
// The driver takes the master view; the frame buffer and panel take the slave view.
interface matrix_driver_if #(
  parameter int unsigned scan_bit = 4
);
  logic [4:0]          addr;
  logic [23:0]         data1;
  logic [23:0]         data2;
  logic [2:0]          rgb1;
  logic [2:0]          rgb2;
  logic                sclk;
  logic                latch;
  logic                oe_b;
  logic [scan_bit-1:0] select;

  modport master (
    output addr, rgb1, rgb2, sclk, latch, oe_b, select,
    input  data1, data2
  );

  modport slave (
    input  addr, rgb1, rgb2, sclk, latch, oe_b, select,
    output data1, data2
  );
endinterface

// File: rtl/matrix_driver.sv
// HUB75 scan driver: shifts one bit-plane per pass, latches it, then shows it for a
// binary-weighted number of ticks (8-plane BCM) before moving to the next plane/row.
module matrix_driver #(
  parameter int unsigned divider  = 3,
  parameter int unsigned length   = 32,
  parameter int unsigned scan_bit = 4
) (
  input logic             clk,
  input logic             reset,
  matrix_driver_if.master bus
);

  localparam int unsigned DivW    = $clog2(divider);
  localparam logic [4:0]  LastCol = 5'(length - 1);

  typedef enum logic [1:0] {StShift, StBlank, StLatch, StDisplay} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                phase_q, phase_d;
  logic [4:0]          col_q, col_d;
  logic [2:0]          plane_q, plane_d;
  logic [12:0]         disp_q, disp_d;
  logic [12:0]         disp_last;
  logic [scan_bit-1:0] select_q, select_d;
  logic [4:0]          addr_q, addr_d;
  logic [2:0]          rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic                sclk_q, sclk_d, latch_q, latch_d, oe_b_q, oe_b_d;
  logic                tick;

  logic [7:0] r1, g1, b1, r2, g2, b2;
  assign {r1, g1, b1} = bus.data1;
  assign {r2, g2, b2} = bus.data2;

  assign tick      = (div_q == DivW'(divider - 1));
  assign disp_last = (13'(length) << plane_q) - 13'd1;

  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    phase_d  = phase_q;
    col_d    = col_q;
    plane_d  = plane_q;
    disp_d   = disp_q;
    select_d = select_q;
    addr_d   = addr_q;
    rgb1_d   = rgb1_q;
    rgb2_d   = rgb2_q;
    sclk_d   = sclk_q;
    latch_d  = latch_q;
    oe_b_d   = oe_b_q;
    if (tick) begin
      case (state_q)
        StShift: begin
          if (!phase_q) begin
            // Falling shift edge: present this column's bits and start fetching the next.
            sclk_d  = 1'b0;
            rgb1_d  = {r1[plane_q], g1[plane_q], b1[plane_q]};
            rgb2_d  = {r2[plane_q], g2[plane_q], b2[plane_q]};
            addr_d  = (col_q == LastCol) ? 5'd0 : col_q + 5'd1;
            phase_d = 1'b1;
          end else begin
            sclk_d  = 1'b1;
            phase_d = 1'b0;
            if (col_q == LastCol) begin
              col_d   = 5'd0;
              state_d = StBlank;
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
        StBlank: begin
          sclk_d  = 1'b0;
          rgb1_d  = 3'b000;
          rgb2_d  = 3'b000;
          state_d = StLatch;
        end
        StLatch: begin
          if (!latch_q) begin
            latch_d = 1'b1;
          end else begin
            latch_d = 1'b0;
            oe_b_d  = 1'b0;
            disp_d  = 13'd0;
            state_d = StDisplay;
          end
        end
        StDisplay: begin
          if (disp_q == disp_last) begin
            oe_b_d  = 1'b1;
            plane_d = plane_q + 3'd1;
            if (plane_q == 3'd7) select_d = select_q + 1'b1;
            state_d = StShift;
          end else begin
            disp_d = disp_q + 13'd1;
          end
        end
        default: state_d = StShift;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StShift;
      div_q    <= '0;
      phase_q  <= 1'b0;
      col_q    <= 5'd0;
      plane_q  <= 3'd0;
      disp_q   <= 13'd0;
      select_q <= '0;
      addr_q   <= 5'd0;
      rgb1_q   <= 3'b000;
      rgb2_q   <= 3'b000;
      sclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      oe_b_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      col_q    <= col_d;
      plane_q  <= plane_d;
      disp_q   <= disp_d;
      select_q <= select_d;
      addr_q   <= addr_d;
      rgb1_q   <= rgb1_d;
      rgb2_q   <= rgb2_d;
      sclk_q   <= sclk_d;
      latch_q  <= latch_d;
      oe_b_q   <= oe_b_d;
    end
  end

  assign bus.addr   = addr_q;
  assign bus.rgb1   = rgb1_q;
  assign bus.rgb2   = rgb2_q;
  assign bus.sclk   = sclk_q;
  assign bus.latch  = latch_q;
  assign bus.oe_b   = oe_b_q;
  assign bus.select = select_q;

endmodule

// File: tb/tb_matrix_driver.sv
// Bench for matrix_driver: walks every pass of several rows against a model of the
// scan order, pixel bit selection and BCM timing, with addr-pattern and random frames.
module tb_matrix_driver;

  localparam int unsigned Div  = 3;
  localparam int unsigned Len  = 5;
  localparam int unsigned Sb   = 2;
  localparam int          Rows = 1 << Sb;

  logic clk = 1'b0;
  logic reset = 1'b1;

  matrix_driver_if #(.scan_bit(Sb)) bus ();

  matrix_driver #(
    .divider (Div),
    .length  (Len),
    .scan_bit(Sb)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   hung = 1'b0;
  bit   use_fb = 1'b0;
  logic prev_sclk, prev_latch;
  logic [23:0] fb1 [128];
  logic [23:0] fb2 [128];

  // Frame buffer with one clock of read latency.
  always @(posedge clk) begin
    if (use_fb) begin
      bus.data1 <= fb1[{bus.select, bus.addr}];
      bus.data2 <= fb2[{bus.select, bus.addr}];
    end else begin
      bus.data1 <= {19'd0, bus.addr};
      bus.data2 <= ~{19'd0, bus.addr};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pixel(input bit upper, input int row, input int col);
    if (use_fb) return upper ? fb1[row * 32 + col] : fb2[row * 32 + col];
    return upper ? 24'(col) : ~24'(col);
  endfunction

  function automatic logic [2:0] plane_bits(input logic [23:0] px, input int p);
    logic [23:0] r, g, b;
    r = (px >> (16 + p)) & 24'd1;
    g = (px >> (8 + p)) & 24'd1;
    b = (px >> p) & 24'd1;
    return {r[0], g[0], b[0]};
  endfunction

  task automatic step();
    prev_sclk  = bus.sclk;
    prev_latch = bus.latch;
    @(negedge clk);
    cyc++;
  endtask

  task automatic sync_prev();
    prev_sclk  = bus.sclk;
    prev_latch = bus.latch;
  endtask

  // One full pass for (row, plane p); abort_at > 0 returns that many clks into display.
  task automatic run_pass(input int row, input int p, input int abort_at);
    int n, w, last_rise;
    bit oe_ok, sel_ok;
    if (hung) return;
    last_rise = 0;
    for (int c = 0; c < Len; c++) begin
      n = 0;
      while (!(bus.sclk && !prev_sclk) && n < 1000) begin step(); n++; end
      if (n >= 1000) begin check("sclk_rise_timeout", 0, 1); hung = 1'b1; return; end
      check("rgb1", bus.rgb1, plane_bits(pixel(1'b1, row, c), p));
      check("rgb2", bus.rgb2, plane_bits(pixel(1'b0, row, c), p));
      check("addr_next", bus.addr, (c == Len - 1) ? 0 : c + 1);
      check("select_shift", bus.select, row);
      check("oe_b_shift", bus.oe_b, 1);
      if (c > 0) check("sclk_period", cyc - last_rise, 2 * Div);
      last_rise = cyc;
      step();
    end
    n = 0;
    while (!(bus.latch && !prev_latch) && n < 1000) begin step(); n++; end
    if (n >= 1000) begin check("latch_timeout", 0, 1); hung = 1'b1; return; end
    check("blank_rgb", {bus.rgb1, bus.rgb2}, 0);
    check("blank_sclk", bus.sclk, 0);
    oe_ok = bus.oe_b;
    w = 1;
    step();
    while (bus.latch && w < 100) begin
      if (!bus.oe_b) oe_ok = 1'b0;
      w++;
      step();
    end
    check("latch_width", w, Div);
    check("latch_oe_b", oe_ok, 1);
    check("oe_b_on", bus.oe_b, 0);
    w = 0;
    sel_ok = 1'b1;
    while (!bus.oe_b && w < Len * 128 * Div + 100 && !(abort_at > 0 && w >= abort_at)) begin
      if (bus.select !== Sb'(row)) sel_ok = 1'b0;
      w++;
      step();
    end
    if (abort_at > 0) return;
    check("oe_low_clks", w, (Len << p) * Div);
    check("select_held", sel_ok, 1);
    check("select_adv", bus.select, (p == 7) ? (row + 1) % Rows : row);
    if (w >= Len * 128 * Div + 100) hung = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, bus.sclk, 0);
    check({tag, "_latch"}, bus.latch, 0);
    check({tag, "_oe_b"}, bus.oe_b, 1);
    check({tag, "_rgb"}, {bus.rgb1, bus.rgb2}, 0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_select"}, bus.select, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_clks;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    sync_prev();

    // Four rows of eight planes with the addr pattern, then the wrapped row 0.
    for (int row = 0; row < Rows; row++)
      for (int p = 0; p < 8; p++) run_pass(row, p, 0);
    run_pass(0, 0, 0);

    for (int i = 0; i < 128; i++) begin
      fb1[i] = 24'($urandom);
      fb2[i] = 24'($urandom);
    end
    use_fb = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_shift");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sync_prev();

    for (int p = 0; p < 8; p++) run_pass(0, p, 0);
    for (int p = 0; p < 3; p++) run_pass(1, p, 0);
    abort_clks = int'($urandom_range(1, 100));
    run_pass(1, 3, abort_clks);
    if (!hung) begin
      check("oe_b_before_reset", bus.oe_b, 0);
      #2 reset = 1'b1;
      #1 check_reset_outputs("reset_display");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sync_prev();
      for (int p = 0; p < 8; p++) run_pass(0, p, 0);
      run_pass(1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
